// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Picks at most one pending functional-unit result per cycle, acknowledges
// it combinationally through req_ready, and drives a registered broadcast
// (cdb_valid/cdb_tag/cdb_val) on the following cycle. Requests carrying the
// reserved NONE tag are acknowledged and dropped, and flagged in tag_err.

module cdb_arbiter #(
   parameter int                NUM_FU = 4,
   parameter int                TAG_W  = 5,
   parameter int                DATA_W = 32,
   parameter logic [TAG_W-1:0]  NONE   = '1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_FU-1:0]          req_valid,
   input  logic [NUM_FU*TAG_W-1:0]    req_tag,
   input  logic [NUM_FU*DATA_W-1:0]   req_val,
   output logic [NUM_FU-1:0]          req_ready,
   input  logic                       cdb_hold,
   output logic                       cdb_valid,
   output logic [TAG_W-1:0]           cdb_tag,
   output logic [DATA_W-1:0]          cdb_val,
   output logic                       tag_err,
   output logic [15:0]                grant_cnt
);

   localparam int               PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_FU - 1);

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  win_idx;
   logic [PTR_W-1:0]  next_ptr;
   logic              win_found;
   logic [TAG_W-1:0]  win_tag;
   logic [DATA_W-1:0] win_val;
   logic              xfer;
   logic              drop;

   logic [TAG_W-1:0]  tag_arr [NUM_FU];
   logic [DATA_W-1:0] val_arr [NUM_FU];

   // Unpack the flat request buses into per-unit arrays for indexed selection
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         tag_arr[i] = req_tag[i*TAG_W +: TAG_W];
         val_arr[i] = req_val[i*DATA_W +: DATA_W];
      end
   end

   // Search rr_ptr, rr_ptr+1, ... (mod NUM_FU) for the first pending unit
   always_comb begin
      logic [PTR_W-1:0] unit;
      unit      = '0;
      win_found = 1'b0;
      win_idx   = '0;
      win_tag   = NONE;
      win_val   = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         unit = PTR_W'((int'(rr_ptr) + k) % NUM_FU);
         if (!win_found && req_valid[unit]) begin
            win_found = 1'b1;
            win_idx   = unit;
            win_tag   = tag_arr[unit];
            win_val   = val_arr[unit];
         end
      end
   end

   // One-hot grant, suppressed by hold and while reset is asserted
   always_comb begin
      req_ready = '0;
      xfer      = rst_n && !cdb_hold && win_found;
      drop      = xfer && (win_tag == NONE);
      next_ptr  = (win_idx == LAST) ? '0 : win_idx + 1'b1;
      if (xfer) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // Round-robin pointer moves past the unit that just transferred
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= next_ptr;
      end
   end

   // Registered broadcast; value holds when nothing valid is broadcast
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= NONE;
         cdb_val   <= '0;
      end else if (xfer && !drop) begin
         cdb_valid <= 1'b1;
         cdb_tag   <= win_tag;
         cdb_val   <= win_val;
      end else begin
         cdb_valid <= 1'b0;
         cdb_tag   <= NONE;
      end
   end

   // Sticky NONE-tag error flag and saturating broadcast counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_err   <= 1'b0;
         grant_cnt <= '0;
      end else begin
         if (drop) begin
            tag_err <= 1'b1;
         end
         if (xfer && !drop && (grant_cnt != 16'hFFFF)) begin
            grant_cnt <= grant_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: self-checking bench for cdb_arbiter (4 units, 5-bit tags).
// Table-driven vectors, hand-written corner sequences, and a randomized run
// compared against a behavioural model of the arbitration rules.

module tb_cdb_arbiter;

   localparam int         N        = 4;
   localparam logic [4:0] NONE_TAG = 5'h1F;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [19:0]  req_tag;
   logic [127:0] req_val;
   logic [3:0]   req_ready;
   logic         cdb_hold;
   logic         cdb_valid;
   logic [4:0]   cdb_tag;
   logic [31:0]  cdb_val;
   logic         tag_err;
   logic [15:0]  grant_cnt;

   cdb_arbiter #(
      .NUM_FU (4),
      .TAG_W  (5),
      .DATA_W (32),
      .NONE   (5'h1F)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_val   (req_val),
      .req_ready (req_ready),
      .cdb_hold  (cdb_hold),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_val   (cdb_val),
      .tag_err   (tag_err),
      .grant_cnt (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [19:0] tags;
      logic        hold;
      logic [3:0]  exp_ready;
      logic        exp_valid;
      logic [4:0]  exp_tag;
   } vec_t;

   localparam logic [19:0]  TAGS_DEF = {5'd13, 5'd12, 5'd11, 5'd10};
   localparam logic [127:0] VALS     = {32'h3333_0003, 32'hDEADBEEF, 32'h1111_0001, 32'hC0DE_0000};

   vec_t vecs [10];

   int checks = 0;
   int passed = 0;

   // behavioural model state
   int          m_ptr;
   logic        m_err;
   int          m_cnt;
   logic        m_valid;
   logic [4:0]  m_tag;
   logic [31:0] m_val;
   int          m_grant;

   logic [3:0]  rdy_seen;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [19:0] t, input logic [127:0] d, input logic h);
      req_valid = v;
      req_tag   = t;
      req_val   = d;
      cdb_hold  = h;
   endtask

   task automatic modelReset();
      m_ptr   = 0;
      m_err   = 1'b0;
      m_cnt   = 0;
      m_valid = 1'b0;
      m_tag   = NONE_TAG;
      m_val   = '0;
      m_grant = -1;
   endtask

   // First requesting unit in the rotating order starting at the pointer
   function automatic int modelWinner();
      if (!rst_n || cdb_hold) return -1;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic modelUpdate();
      logic [4:0]  t;
      logic [31:0] v;
      m_grant = modelWinner();
      if (m_grant >= 0) begin
         t = 5'(req_tag >> (m_grant * 5));
         v = 32'(req_val >> (m_grant * 32));
         m_ptr = (m_grant + 1) % N;
         if (t == NONE_TAG) begin
            m_err   = 1'b1;
            m_valid = 1'b0;
            m_tag   = NONE_TAG;
         end else begin
            m_valid = 1'b1;
            m_tag   = t;
            m_val   = v;
            if (m_cnt < 65535) m_cnt++;
         end
      end else begin
         m_valid = 1'b0;
         m_tag   = NONE_TAG;
      end
   endtask

   // Sample grant mid-cycle, advance model at the edge, settle outputs
   task automatic doCycle();
      @(negedge clk);
      rdy_seen = req_ready;
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      applyStimulus(4'b0000, TAGS_DEF, VALS, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit          pend [4];
      logic [4:0]  ptag [4];
      logic [31:0] pval [4];
      logic [3:0]  er;

      vecs[0] = '{4'b1111, TAGS_DEF,                          1'b0, 4'b0001, 1'b1, 5'd10};
      vecs[1] = '{4'b0100, {5'd13, 5'd3, 5'd11, 5'd10},       1'b0, 4'b0100, 1'b1, 5'd3};
      vecs[2] = '{4'b0000, TAGS_DEF,                          1'b0, 4'b0000, 1'b0, 5'h1F};
      vecs[3] = '{4'b0011, TAGS_DEF,                          1'b1, 4'b0000, 1'b0, 5'h1F};
      vecs[4] = '{4'b0011, TAGS_DEF,                          1'b0, 4'b0001, 1'b1, 5'd10};
      vecs[5] = '{4'b0011, TAGS_DEF,                          1'b0, 4'b0010, 1'b1, 5'd11};
      vecs[6] = '{4'b1001, TAGS_DEF,                          1'b0, 4'b1000, 1'b1, 5'd13};
      vecs[7] = '{4'b1000, {5'h1F, 5'd12, 5'd11, 5'd10},      1'b0, 4'b1000, 1'b0, 5'h1F};
      vecs[8] = '{4'b1010, TAGS_DEF,                          1'b0, 4'b0010, 1'b1, 5'd11};
      vecs[9] = '{4'b0101, TAGS_DEF,                          1'b0, 4'b0100, 1'b1, 5'd12};

      // reset with every unit requesting
      rst_n = 1'b0;
      applyStimulus(4'b1111, TAGS_DEF, VALS, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst ready", 32'(req_ready), 32'h0);
      checkOutput("rst cdb_valid", 32'(cdb_valid), 32'h0);
      checkOutput("rst cdb_tag", 32'(cdb_tag), 32'h1F);
      checkOutput("rst cdb_val", cdb_val, 32'h0);
      checkOutput("rst tag_err", 32'(tag_err), 32'h0);
      checkOutput("rst grant_cnt", 32'(grant_cnt), 32'h0);
      rst_n = 1'b1;
      #1;
      checkOutput("rst first grant", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      checkOutput("rst first tag", 32'(cdb_tag), 32'd10);

      // table vectors from a fresh reset
      resetDut();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].tags, VALS, vecs[i].hold);
         doCycle();
         checkOutput($sformatf("tbl%0d ready", i), 32'(rdy_seen), 32'(vecs[i].exp_ready));
         checkOutput($sformatf("tbl%0d cdb_valid", i), 32'(cdb_valid), 32'(vecs[i].exp_valid));
         checkOutput($sformatf("tbl%0d cdb_tag", i), 32'(cdb_tag), 32'(vecs[i].exp_tag));
      end
      checkOutput("tbl tag_err", 32'(tag_err), 32'h1);
      checkOutput("tbl grant_cnt", 32'(grant_cnt), 32'd7);

      // single request from unit 2, then one-cycle broadcast
      resetDut();
      applyStimulus(4'b0100, {5'd13, 5'd3, 5'd11, 5'd10}, VALS, 1'b0);
      doCycle();
      checkOutput("u2 ready", 32'(rdy_seen), 32'b0100);
      checkOutput("u2 cdb_valid", 32'(cdb_valid), 32'h1);
      checkOutput("u2 cdb_tag", 32'(cdb_tag), 32'd3);
      checkOutput("u2 cdb_val", cdb_val, 32'hDEADBEEF);
      applyStimulus(4'b0000, TAGS_DEF, VALS, 1'b0);
      doCycle();
      checkOutput("u2 cdb_valid drop", 32'(cdb_valid), 32'h0);
      checkOutput("u2 cdb_tag idle", 32'(cdb_tag), 32'h1F);
      checkOutput("u2 cdb_val hold", cdb_val, 32'hDEADBEEF);

      // all units request continuously: strict rotation
      resetDut();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(4'b1111, TAGS_DEF, VALS, 1'b0);
         doCycle();
         checkOutput($sformatf("rot%0d ready", c), 32'(rdy_seen), 32'(1 << (c % 4)));
         checkOutput($sformatf("rot%0d tag", c), 32'(cdb_tag), 32'(10 + (c % 4)));
      end
      checkOutput("rot grant_cnt", 32'(grant_cnt), 32'd8);

      // hold blocks grants and broadcasts, requests stay pending
      resetDut();
      applyStimulus(4'b1010, TAGS_DEF, VALS, 1'b1);
      for (int c = 0; c < 3; c++) begin
         doCycle();
         checkOutput($sformatf("hold%0d ready", c), 32'(rdy_seen), 32'h0);
         checkOutput($sformatf("hold%0d cdb_valid", c), 32'(cdb_valid), 32'h0);
      end
      applyStimulus(4'b1010, TAGS_DEF, VALS, 1'b0);
      doCycle();
      checkOutput("hold release ready", 32'(rdy_seen), 32'b0010);
      checkOutput("hold release tag", 32'(cdb_tag), 32'd11);
      applyStimulus(4'b1000, TAGS_DEF, VALS, 1'b0);
      doCycle();
      checkOutput("hold second ready", 32'(rdy_seen), 32'b1000);
      checkOutput("hold second tag", 32'(cdb_tag), 32'd13);

      // NONE tag is acknowledged, dropped, and flagged
      resetDut();
      applyStimulus(4'b0001, {5'd13, 5'd12, 5'd11, 5'h1F}, VALS, 1'b0);
      doCycle();
      checkOutput("none ready", 32'(rdy_seen), 32'b0001);
      checkOutput("none cdb_valid", 32'(cdb_valid), 32'h0);
      checkOutput("none cdb_tag", 32'(cdb_tag), 32'h1F);
      checkOutput("none tag_err", 32'(tag_err), 32'h1);
      checkOutput("none grant_cnt", 32'(grant_cnt), 32'h0);
      applyStimulus(4'b0011, TAGS_DEF, VALS, 1'b0);
      doCycle();
      checkOutput("none next ready", 32'(rdy_seen), 32'b0010);
      checkOutput("none next tag", 32'(cdb_tag), 32'd11);
      checkOutput("none sticky", 32'(tag_err), 32'h1);

      // reset the cycle after a grant discards the broadcast
      resetDut();
      applyStimulus(4'b0100, TAGS_DEF, VALS, 1'b0);
      doCycle();
      checkOutput("midrst pre valid", 32'(cdb_valid), 32'h1);
      checkOutput("midrst pre cnt", 32'(grant_cnt), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst cdb_valid", 32'(cdb_valid), 32'h0);
      checkOutput("midrst cdb_tag", 32'(cdb_tag), 32'h1F);
      checkOutput("midrst grant_cnt", 32'(grant_cnt), 32'h0);
      checkOutput("midrst ready", 32'(req_ready), 32'h0);

      // randomized traffic against the model
      resetDut();
      for (int u = 0; u < N; u++) begin
         pend[u] = 1'b0;
         ptag[u] = '0;
         pval[u] = '0;
      end
      for (int c = 0; c < 500; c++) begin
         for (int u = 0; u < N; u++) begin
            if (!pend[u] && ($urandom_range(0, 1) == 1)) begin
               pend[u] = 1'b1;
               ptag[u] = ($urandom_range(0, 9) == 0) ? NONE_TAG : 5'($urandom_range(0, 30));
               pval[u] = $urandom;
            end
         end
         applyStimulus({pend[3], pend[2], pend[1], pend[0]},
                       {ptag[3], ptag[2], ptag[1], ptag[0]},
                       {pval[3], pval[2], pval[1], pval[0]},
                       ($urandom_range(0, 4) == 0));
         doCycle();
         er = (m_grant >= 0) ? 4'(1 << m_grant) : 4'b0000;
         if (m_grant >= 0) pend[m_grant] = 1'b0;
         checkOutput($sformatf("rnd%0d ready", c), 32'(rdy_seen), 32'(er));
         checkOutput($sformatf("rnd%0d cdb_valid", c), 32'(cdb_valid), 32'(m_valid));
         checkOutput($sformatf("rnd%0d cdb_tag", c), 32'(cdb_tag), 32'(m_tag));
         checkOutput($sformatf("rnd%0d cdb_val", c), cdb_val, m_val);
         checkOutput($sformatf("rnd%0d tag_err", c), 32'(tag_err), 32'(m_err));
         checkOutput($sformatf("rnd%0d grant_cnt", c), 32'(grant_cnt), 32'(m_cnt));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
